// File: rtl/mod_acc64_if.sv
// Stream bundle for mod_acc64: residue input side, reduced-sum output side and
// the sticky overflow flag. The slave modport is the accumulator's view.
interface mod_acc64_if #(
  parameter int unsigned P_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH = 5
);
  logic [P_WIDTH-1:0]   N_in;
  logic [P_WIDTH-1:0]   din;
  logic                 din_valid;
  logic                 din_last;
  logic                 din_ready;
  logic [P_WIDTH-1:0]   dout;
  logic [CNT_WIDTH-1:0] dout_cnt;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 ovf_err;

  modport master (
    output N_in, din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_cnt, dout_valid, ovf_err
  );

  modport slave (
    input  N_in, din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_cnt, dout_valid, ovf_err
  );
endinterface

// File: rtl/mod_acc64.sv
// Streaming modular accumulator: sums frames of residues mod N_in and queues
// one {sum, beat count} per frame in a small output FIFO.
module mod_acc64 #(
  parameter int unsigned P_WIDTH    = 64,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned CNT_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  mod_acc64_if.slave  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_LEN - 1);
  localparam logic [OCC_W-1:0]     FULL_OCC = OCC_W'(FIFO_DEPTH);

  logic [P_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [P_WIDTH-1:0]   mem_sum [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] mem_cnt [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;

  logic [P_WIDTH:0]     sum_ext, red_ext;
  logic [P_WIDTH-1:0]   madd, sum;
  logic                 ready, accept, close, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Both operands are below N_in, so a single conditional subtract reduces.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, bus.din};
    red_ext = sum_ext - {1'b0, bus.N_in};
    madd    = (sum_ext >= {1'b0, bus.N_in}) ? red_ext[P_WIDTH-1:0]
                                            : sum_ext[P_WIDTH-1:0];
    sum     = (cnt == '0) ? bus.din : madd;
    ready   = (occ < FULL_OCC);
    accept  = bus.din_valid & ready;
    close   = bus.din_last | (cnt == LAST_CNT);
    push    = accept & close;
    pop     = (occ != '0) & bus.dout_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc <= '0;
        cnt <= '0;
        if (!bus.din_last) ovf <= 1'b1;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_sum[i] <= '0;
        mem_cnt[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem_sum[wr_ptr] <= sum;
        mem_cnt[wr_ptr] <= cnt + 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout       = mem_sum[rd_ptr];
  assign bus.dout_cnt   = mem_cnt[rd_ptr];
  assign bus.dout_valid = (occ != '0);
  assign bus.ovf_err    = ovf;

endmodule
